// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit/receive path.
// Contents: 3-bit state encoding, default character width and baud divisor,
// and a frame-length helper. When UART_TX_PARITY_EN is defined, every frame
// carries one extra even-parity bit.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned UART_DATA_WIDTH   = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200

`ifdef UART_TX_PARITY_EN
  localparam int unsigned UART_PARITY_BITS = 1;
`else
  localparam int unsigned UART_PARITY_BITS = 0;
`endif

  // Serial bits per frame: start + data + optional parity + stop.
  function automatic int unsigned uart_frame_bits(input int unsigned data_width);
    return data_width + 2 + UART_PARITY_BITS;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if: read side of a first-word-fall-through FIFO.
//   empty   - FIFO empty flag (driven by the FIFO)
//   data_in - head word, valid whenever empty=0 (driven by the FIFO)
//   deQ     - single-cycle dequeue strobe (driven by the reader)
// Modports: master = reader (this UART transmitter), slave = FIFO.
interface uart_tx_fifo_drain_if #(
  parameter int unsigned DATA_WIDTH = uart_pkg::UART_DATA_WIDTH
);
  logic                  empty;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  deQ;

  modport master (input empty, input data_in, output deQ);
  modport slave  (output empty, output data_in, input deQ);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, counts 0..CLKS_PER_BIT-1.
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   clr_i - synchronous clear, holds the count at 0
//   tc_o  - high for the single cycle in which the count is at its last value
// The count only wraps through the terminal-count clear, so it never exceeds
// CLKS_PER_BIT-1. Shared with the receiver.
module uart_baud_gen #(
  parameter  int unsigned CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT,
  localparam int unsigned CNT_WIDTH    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CLKS_PER_BIT - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tc_q, tc_d;

  // tc is precomputed from the next count so the flag is registered yet
  // coincides exactly with the cycle where cnt_q == CNT_MAX.
  always_comb begin
    cnt_d = cnt_q + CNT_WIDTH'(1);
    if (clr_i || tc_q) begin
      cnt_d = '0;
    end
    tc_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: UART transmitter draining a first-word-fall-through FIFO.
//   clock - system clock
//   reset - asynchronous active-high reset
//   fifo  - FIFO read port (master side: empty/data_in in, deQ out; deQ is
//           combinational, one cycle per accepted byte)
//   tx    - serial line, idle high, registered
//   busy  - high while a frame is in progress, registered
// Frames are 8N1, LSB first; with UART_TX_PARITY_EN defined an even-parity
// bit is inserted between the data bits and the stop bit (8E1).
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_tx_fifo_drain_if.master fifo,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned           IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_WIDTH-1:0]  IDX_LAST  = IDX_WIDTH'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  deq_c;
  logic                  tc;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // Bit timer runs only while a frame is in flight.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clock),
    .rst   (reset),
    .clr_i (state_q == IDLE),
    .tc_o  (tc)
  );

  // Next-state, datapath and registered-output precompute.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    deq_c   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!fifo.empty && !reset) begin
          deq_c   = 1'b1;
          shift_d = fifo.data_in;
          idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo.data_in;
`endif
          state_d = START;
        end
      end
      START: begin
        if (tc) state_d = DATA;
      end
      DATA: begin
        if (tc) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tc) state_d = STOP;
      end
`endif
      STOP: begin
        if (tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // tx follows the state being entered so it changes on the same edge.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`endif

  assign fifo.deQ = deq_c;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Serial UART transmitter that sits directly downstream of the first-word-fall-through transmit FIFO in the SoC UART path.
- Consumes the FIFO's empty flag and its fall-through head word, and issues a single-cycle dequeue for each byte it accepts.
- Shifts each accepted byte out on the tx line as 8N1 (or 8E1, see Optional Feature), LSB first.
- The CPU-side bus writes into the FIFO; this block is the only reader.

Parameters:
- DATA_WIDTH, 8, bits per character; also the width of the FIFO data port.
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200). Legal range is >= 2.
- CNT_WIDTH, $clog2(CLKS_PER_BIT), width of the baud counter. Derived; never overridden.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- empty  input  1  FIFO empty flag.
- data_in  input  DATA_WIDTH  FIFO head word (fall-through, valid whenever empty=0).
- deQ  output  1  FIFO dequeue strobe; combinational, one cycle per accepted byte.
- tx  output  1  serial line, idle high; registered.
- busy  output  1  high whenever a frame is in progress (state != IDLE); registered.

Behaviour:
- Reset is asynchronous and active-high:
  - state=IDLE, tx=1, busy=0, baud counter=0, bit index=0, shift register=0.
  - deQ=0 while reset is asserted.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - deQ = (state==IDLE) & ~empty & ~reset.
  - In a cycle T with deQ=1: latch data_in into the shift register, clear the baud counter, next state=START.
  - tx falls to 0 at the T+1 edge.
- Every non-IDLE state lasts exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1; the state or bit advances on terminal count.
  - The counter restarts at 0 on every advance.
- START: tx=0.
- DATA: tx = shift_reg[0]; shift right at the end of each bit; the bit index runs 0..DATA_WIDTH-1, then the next state.
- STOP: tx=1. At terminal count, go to IDLE.
- Timing:
  - IDLE always lasts at least 1 cycle between frames.
  - Back-to-back deQ pulses are spaced exactly (2+DATA_WIDTH)*CLKS_PER_BIT + 1 cycles apart. With PARITY, add CLKS_PER_BIT.
  - There is no mid-frame dequeue. empty and data_in are ignored outside IDLE.
- deQ is never asserted while empty=1. No byte is dequeued twice or skipped.
- Reset mid-frame: tx returns to 1 and busy to 0 immediately, without a clock edge. The in-flight byte is discarded; it has already been dequeued.
- The baud counter must never exceed CLKS_PER_BIT-1. It wraps only via terminal-count clear.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the latched byte (even parity), computed at latch time and held in a 1-bit register.
  - The frame is 11 bits.
- Undefined:
  - No PARITY state and no parity register.
  - The frame is 10 bits.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit.
  - Default CLKS_PER_BIT constant.
  - Frame-length helper constant.
- Sub-module uart_baud_gen:
  - Parameterised counter with a sync clear input and a terminal-count pulse output.
  - Reset asynchronous active-high.
  - Reused by the future receiver.

Test Plan:
Run all scenarios with CLKS_PER_BIT=4.
- Assert reset with no clock running -> tx=1, busy=0, deQ=0 immediately; hold 3 cycles, no change.
- empty=0, data_in=0xA5 at T:
  - deQ=1 only in cycle T.
  - From T+1, tx over 4-cycle bits = 0,1,0,1,0,0,1,0,1,1.
  - busy=1 for 40 cycles, then busy=0.
- FIFO preloaded with 0x00 then 0xFF:
  - The second deQ occurs exactly 41 cycles after the first.
  - Second frame tx = 0, eight 1s, 1.
- empty held 1 for 100 cycles with data_in toggling -> deQ=0, tx=1, busy=0 throughout.
- Async reset asserted mid-DATA bit 3 of 0x3C:
  - tx=1, busy=0 before the next edge.
  - After release with empty=0 and data 0x81, a clean frame starts with deQ in the first post-reset cycle.
- With UART_TX_PARITY_EN, data 0x07:
  - Parity bit = 1, frame = 11 bits (44 cycles).
  - Next deQ is spaced 45 cycles after the first.
